lcdi_stream_packer: RTL

- Downstream stage of the LCDI interpolator. Consumes its 4-pixel output beats (data0..3_out qualified by data_out_valid) plus line_end/frame_end markers.
- Packs each beat into one wide word and buffers it in a small FIFO. Emits it on a ready/valid stream with start-of-frame (user) and end-of-line (last) sideband for the frame writer.
- LCDI has no backpressure, so this block absorbs downstream stalls, flags overflow, and checks line/frame geometry.

---
 rtl/lcdi_pkg.sv | 21 ++
 rtl/lcdi_stream_packer_if.sv | 28 ++
 rtl/lcdi_sync_fifo.sv | 47 ++++
 rtl/lcdi_stream_packer.sv | 138 +++++++++++++
 4 files changed

// File: rtl/lcdi_pkg.sv
// Shared types for the LCDI stream packer: pixel/beat types and the frame FSM states.
package lcdi_pkg;

   localparam int PIX_W = 8;

   typedef logic [PIX_W-1:0] pix_t;

   // One FIFO entry; packed order matches {eof, eol, sof, d3, d2, d1, d0}.
   typedef struct packed {
      logic        eof;
      logic        eol;
      logic        sof;
      pix_t [3:0]  d;
   } beat_t;

   typedef enum logic {
      WAIT_SOF = 1'b0,
      ACTIVE   = 1'b1
   } fsm_e;

endpackage

// File: rtl/lcdi_stream_packer_if.sv
// Ready/valid output stream of the packer (packed word plus SOF/EOL sideband).
interface lcdi_stream_packer_if #(
   parameter int DATA_WIDTH = 8
) ();

   logic [4*DATA_WIDTH-1:0] m_data;
   logic                    m_valid;
   logic                    m_ready;
   logic                    m_last;
   logic                    m_user;

   modport master (
      output m_data,
      output m_valid,
      output m_last,
      output m_user,
      input  m_ready
   );

   modport slave (
      input  m_data,
      input  m_valid,
      input  m_last,
      input  m_user,
      output m_ready
   );

endinterface

// File: rtl/lcdi_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; a push while full is accepted if a pop happens in the same cycle.
module lcdi_sync_fifo #(
   parameter int WIDTH = 35,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rd_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_do_push;
   logic             w_do_pop;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);
   assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

   // Pointer update; reset empties the FIFO.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
   end

endmodule

// File: rtl/lcdi_stream_packer.sv
// Packs LCDI 4-pixel beats into wide words, buffers them, and tracks frame geometry and overflow.
module lcdi_stream_packer
   import lcdi_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int FIFO_DEPTH  = 16,
   parameter int LINE_BEATS  = 480,
   parameter int FRAME_LINES = 1080
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] data0_in,
   input  logic [DATA_WIDTH-1:0] data1_in,
   input  logic [DATA_WIDTH-1:0] data2_in,
   input  logic [DATA_WIDTH-1:0] data3_in,
   input  logic                  in_line_end,
   input  logic                  in_frame_end,
   lcdi_stream_packer_if.master  m,
   output logic                  frame_done,
   output logic                  overflow,
   output logic                  geom_err,
   input  logic                  err_clr
);

   localparam int PW = 4 * DATA_WIDTH;
   localparam int EW = PW + 3;
   localparam int BW = $clog2(LINE_BEATS + 1) + 1;
   localparam int LW = $clog2(FRAME_LINES + 1) + 1;

   fsm_e            r_state;
   fsm_e            w_state_nxt;
   logic            w_sof;
   logic [BW-1:0]   r_beat_cnt;
   logic [LW-1:0]   r_line_cnt;
   logic [EW-1:0]   w_wr_data;
   logic [EW-1:0]   w_rd_data;
   logic            w_full;
   logic            w_empty;
   logic            w_pop;
   logic            w_drop;
   logic            w_geom_set;
   logic            r_frame_done;
   logic            r_overflow;
   logic            r_geom_err;

   assign w_wr_data = {in_frame_end, in_line_end, w_sof, data3_in, data2_in, data1_in, data0_in};
   assign w_pop     = !w_empty && m.m_ready;
   assign w_drop    = in_valid && w_full && !w_pop;

   lcdi_sync_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .i_push    (in_valid),
      .i_wr_data (w_wr_data),
      .i_pop     (w_pop),
      .o_rd_data (w_rd_data),
      .o_full    (w_full),
      .o_empty   (w_empty)
   );

   // Outputs are forced to zero while the FIFO is empty so idle/reset values are clean.
   assign m.m_valid = !w_empty;
   assign m.m_data  = w_empty ? '0 : w_rd_data[PW-1:0];
   assign m.m_user  = !w_empty && w_rd_data[PW];
   assign m.m_last  = !w_empty && w_rd_data[PW+1];

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= WAIT_SOF;
      else     r_state <= w_state_nxt;
   end

   // FSM next state: any beat leaves WAIT_SOF unless it also ends the frame.
   always_comb begin
      w_state_nxt = r_state;
      if (in_valid) begin
         if (in_frame_end) w_state_nxt = WAIT_SOF;
         else              w_state_nxt = ACTIVE;
      end
   end

   // FSM output: the first beat after WAIT_SOF is tagged start-of-frame.
   always_comb begin
      w_sof = (r_state == WAIT_SOF);
   end

   // Geometry errors are judged on the input stream, whether or not the beat was stored.
   always_comb begin
      w_geom_set = 1'b0;
      if (in_valid) begin
         if (in_line_end && (r_beat_cnt != BW'(LINE_BEATS - 1)))   w_geom_set = 1'b1;
         if (!in_line_end && (r_beat_cnt >= BW'(LINE_BEATS - 1)))  w_geom_set = 1'b1;
         if (in_frame_end && (r_line_cnt != LW'(FRAME_LINES - 1))) w_geom_set = 1'b1;
      end
   end

   // Beat/line counters; both saturate rather than wrap on runaway input.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_beat_cnt <= '0;
         r_line_cnt <= '0;
      end else if (in_valid) begin
         if (in_frame_end) begin
            r_beat_cnt <= '0;
            r_line_cnt <= '0;
         end else if (in_line_end) begin
            r_beat_cnt <= '0;
            if (r_line_cnt != '1) r_line_cnt <= r_line_cnt + 1'b1;
         end else if (r_beat_cnt != '1) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
         end
      end
   end

   // Sticky error flags and the frame-done pulse; a set event beats err_clr.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_overflow   <= 1'b0;
         r_geom_err   <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= w_pop && w_rd_data[PW+2];
         if (w_drop)       r_overflow <= 1'b1;
         else if (err_clr) r_overflow <= 1'b0;
         if (w_geom_set)   r_geom_err <= 1'b1;
         else if (err_clr) r_geom_err <= 1'b0;
      end
   end

   assign frame_done = r_frame_done;
   assign overflow   = r_overflow;
   assign geom_err   = r_geom_err;

endmodule
